// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and decode helper for the instruction fetch sequencer.
package instr_fetch_pkg;

    localparam int PROG_DEPTH   = 32;
    localparam int ADDR_W       = $clog2(PROG_DEPTH);
    localparam int DATA_W       = 16;
    localparam int EXEC_TIMEOUT = 8;
    localparam int TMR_W        = $clog2(EXEC_TIMEOUT);

    localparam logic [DATA_W-1:0] HALT_WORD = 16'hFFFF;
    localparam logic [2:0]        OP_MVI    = 3'b001;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        IMM    = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    // mvi carries a trailing immediate word
    function automatic logic is_mvi(input logic [DATA_W-1:0] word);
        return word[8:6] == OP_MVI;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load and core-side signals of the fetch sequencer, bundled for port hookup.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              start;
    logic              done;
    logic              run;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              err;

    modport master (
        output ld_valid, ld_addr, ld_data, start, done,
        input  ld_ready, run, din, pc, halted, err
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, start, done,
        output ld_ready, run, din, pc, halted, err
    );

endinterface

// File: rtl/instr_fetch_prog_ram.sv
// Program store: 32x16 RAM with one write port and one registered read port.
// Contents are never reset so a program survives a core reset.
module prog_ram
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [PROG_DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: loads a program, then feeds instructions and
// immediates to the core one at a time, with a watchdog on each execution.
//
//   state  | meaning
//   IDLE   | after reset; program load allowed, waiting for start
//   FETCH  | read of mem[pc] issued
//   DECODE | instruction word on RAM output; read of mem[pc+1] issued
//   IMM    | immediate word on RAM output (mvi only)
//   EXEC   | run high, waiting for core done or watchdog expiry
//   HALT   | halt word or timeout seen; program load allowed, waiting for start
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    instr_fetch_if.slave bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_imm;
    logic              r_mvi;
    logic [TMR_W-1:0]  r_cnt;
    logic              r_run;
    logic [DATA_W-1:0] r_din;
    logic              r_halted;
    logic              r_err;
    logic              r_ld_ready;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_pc_inc1;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    assign w_wr_en   = bus.ld_valid & r_ld_ready;
    assign w_pc_inc1 = r_pc + ADDR_W'(1);
    // DECODE prefetches the word after the instruction so IMM has it without a stall
    assign w_rd_addr = (r_state == DECODE) ? w_pc_inc1 : r_pc;

    prog_ram u_prog_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.ld_addr),
        .i_wr_data (bus.ld_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_imm      <= '0;
            r_mvi      <= 1'b0;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_din      <= '0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
            r_ld_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        r_state    <= FETCH;
                        r_pc       <= '0;
                        r_err      <= 1'b0;
                        r_halted   <= 1'b0;
                        r_ld_ready <= 1'b0;
                    end
                end
                FETCH: begin
                    r_state <= DECODE;
                end
                DECODE: begin
                    r_ir  <= w_rd_data;
                    r_mvi <= is_mvi(w_rd_data);
                    if (w_rd_data == HALT_WORD) begin
                        r_state    <= HALT;
                        r_halted   <= 1'b1;
                        r_ld_ready <= 1'b1;
                    end else if (is_mvi(w_rd_data)) begin
                        r_state <= IMM;
                    end else begin
                        r_state <= EXEC;
                        r_run   <= 1'b1;
                        r_din   <= w_rd_data;
                        r_cnt   <= '0;
                    end
                end
                IMM: begin
                    r_imm   <= w_rd_data;
                    r_state <= EXEC;
                    r_run   <= 1'b1;
                    r_din   <= r_ir;
                    r_cnt   <= '0;
                end
                EXEC: begin
                    if (bus.done) begin
                        r_pc    <= r_pc + (r_mvi ? ADDR_W'(2) : ADDR_W'(1));
                        r_state <= FETCH;
                        r_run   <= 1'b0;
                        r_din   <= '0;
                    end else if (r_cnt == TMR_W'(EXEC_TIMEOUT - 1)) begin
                        r_err      <= 1'b1;
                        r_state    <= HALT;
                        r_halted   <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_run      <= 1'b0;
                        r_din      <= '0;
                    end else begin
                        r_cnt <= r_cnt + TMR_W'(1);
                        r_din <= r_mvi ? r_imm : r_ir;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready = r_ld_ready;
    assign bus.run      = r_run;
    assign bus.din      = r_din;
    assign bus.pc       = r_pc;
    assign bus.halted   = r_halted;
    assign bus.err      = r_err;

endmodule
